// File: rtl/lif_neuron_array_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron array.
package lif_neuron_array_pkg;

  localparam int LIF_N_NEURONS_DEF = 10;
  localparam int LIF_MEM_W_DEF     = 32;
  localparam int LIF_IDX_W         = 4;

  localparam logic LIF_RESET_SOFT = 1'b0;
  localparam logic LIF_RESET_HARD = 1'b1;

  // Spike event: index of the neuron that fired (wide enough for 16 neurons).
  typedef struct packed {
    logic [LIF_IDX_W-1:0] idx;
  } lif_spike_t;

endpackage

// File: rtl/lif_neuron_array_spike_queue.sv
// Circular spike queue: up to NPUSH pushes per cycle in ascending slot order,
// one pop per cycle, pop is applied first so its slot is reusable the same cycle.
module lif_spike_queue #(
  parameter int DEPTH = 32,
  parameter int DW    = 4,
  parameter int NPUSH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic [NPUSH-1:0]         i_push,
  input  logic [NPUSH*DW-1:0]      i_push_data,
  input  logic                     i_pop,
  output logic [NPUSH-1:0]         o_accept,
  output logic                     o_empty,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic [CW-1:0] w_free_eff;
  logic [CW-1:0] w_n;
  logic [PW-1:0] w_slot [NPUSH];

  assign w_pop      = i_pop && (r_count != {CW{1'b0}});
  assign w_free_eff = CW'(DEPTH) - r_count + CW'(w_pop);

  // Grant pushes in index order until the post-pop free space runs out.
  always_comb begin
    w_n      = {CW{1'b0}};
    o_accept = {NPUSH{1'b0}};
    for (int i = 0; i < NPUSH; i++) begin
      w_slot[i] = r_wptr + w_n[PW-1:0];
      if (i_push[i] && (w_n < w_free_eff)) begin
        o_accept[i] = 1'b1;
        w_n         = w_n + CW'(1);
      end else begin
        o_accept[i] = 1'b0;
      end
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {DW{1'b0}};
    end else if (i_clear) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < NPUSH; i++) begin
        if (o_accept[i]) r_mem[w_slot[i]] <= i_push_data[i*DW +: DW];
      end
      r_wptr  <= r_wptr + w_n[PW-1:0];
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count - CW'(w_pop) + w_n;
    end
  end

  assign o_empty = (r_count == {CW{1'b0}});
  assign o_head  = r_mem[r_rptr];
  assign o_free  = CW'(DEPTH) - r_count;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons feeding a valid/ready spike stream.
// Define LIF_SPIKE_CNT_EN to build per-neuron 16-bit saturating spike counters.
module lif_neuron_array
  import lif_neuron_array_pkg::*;
#(
  parameter int N_NEURONS = LIF_N_NEURONS_DEF,
  parameter int IN_W      = 9,
  parameter int MEM_W     = LIF_MEM_W_DEF,
  parameter int QDEPTH    = 32,
  parameter int REFRAC_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [N_NEURONS*IN_W-1:0]    in_data,
  input  logic [2:0]                   in_shift,
  input  logic                         step_end,
  input  logic [MEM_W-2:0]             threshold,
  input  logic [4:0]                   leak_shift,
  input  logic                         reset_mode,
  input  logic [REFRAC_W-1:0]          refrac_steps,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] out_idx,
  output logic                         overflow,
  input  logic [$clog2(N_NEURONS)-1:0] cnt_sel,
  output logic [15:0]                  cnt_data
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int DW = $bits(lif_spike_t);

  logic [N_NEURONS-1:0]    w_fire;
  logic [N_NEURONS-1:0]    w_accept;
  logic [N_NEURONS*DW-1:0] w_push_data;
  logic signed [MEM_W-1:0] w_thr;
  logic                    w_leak_en;
  logic                    w_q_empty;
  logic [DW-1:0]           w_q_head;
  lif_spike_t              w_head;
  logic [$clog2(QDEPTH):0] w_unused_q_free;
  logic                    r_overflow;

  assign w_thr     = $signed({1'b0, threshold});
  assign w_leak_en = step_end && (leak_shift != 5'd0);

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    logic signed [IN_W-1:0]  w_in;
    logic signed [MEM_W-1:0] w_ext;
    logic signed [MEM_W-1:0] w_add;
    logic signed [MEM_W:0]   w_sum;
    logic signed [MEM_W-1:0] w_sat;
    logic signed [MEM_W-1:0] w_m1;
    logic signed [MEM_W-1:0] w_m2;
    logic                    w_int_en;
    logic [REFRAC_W-1:0]     w_rf1;
    logic [REFRAC_W-1:0]     w_rf2;
    logic signed [MEM_W-1:0] r_mem;
    logic [REFRAC_W-1:0]     r_ref;

    assign w_in     = in_data[gi*IN_W +: IN_W];
    assign w_ext    = w_in;
    assign w_add    = w_ext <<< in_shift;
    assign w_sum    = {r_mem[MEM_W-1], r_mem} + {w_add[MEM_W-1], w_add};
    assign w_int_en = in_valid && (r_ref == {REFRAC_W{1'b0}});

    // Clamp the one-bit-wider sum back into the signed membrane range.
    always_comb begin
      if (w_sum[MEM_W] != w_sum[MEM_W-1]) begin
        w_sat = w_sum[MEM_W] ? {1'b1, {(MEM_W-1){1'b0}}} : {1'b0, {(MEM_W-1){1'b1}}};
      end else begin
        w_sat = w_sum[MEM_W-1:0];
      end
    end

    assign w_fire[gi] = w_int_en && (w_sat >= w_thr);

    // Membrane after integration and fire reset; leak is layered on top.
    always_comb begin
      if (!w_int_en) begin
        w_m1 = r_mem;
      end else if (!w_fire[gi]) begin
        w_m1 = w_sat;
      end else if (reset_mode == LIF_RESET_HARD) begin
        w_m1 = {MEM_W{1'b0}};
      end else begin
        w_m1 = w_sat - w_thr;
      end
    end

    assign w_m2  = w_leak_en ? (w_m1 - (w_m1 >>> leak_shift)) : w_m1;
    assign w_rf1 = w_fire[gi] ? refrac_steps : r_ref;
    assign w_rf2 = (step_end && (w_rf1 != {REFRAC_W{1'b0}})) ? (w_rf1 - REFRAC_W'(1)) : w_rf1;
    assign w_push_data[gi*DW +: DW] = DW'(gi);

    // Per-neuron membrane and refractory state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem <= {MEM_W{1'b0}};
        r_ref <= {REFRAC_W{1'b0}};
      end else if (clear) begin
        r_mem <= {MEM_W{1'b0}};
        r_ref <= {REFRAC_W{1'b0}};
      end else begin
        r_mem <= w_m2;
        r_ref <= w_rf2;
      end
    end
  end

  lif_spike_queue #(
    .DEPTH (QDEPTH),
    .DW    (DW),
    .NPUSH (N_NEURONS)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (clear),
    .i_push      (w_fire),
    .i_push_data (w_push_data),
    .i_pop       (out_ready),
    .o_accept    (w_accept),
    .o_empty     (w_q_empty),
    .o_head      (w_q_head),
    .o_free      (w_unused_q_free)
  );

  assign w_head    = w_q_head;
  assign out_valid = !w_q_empty;
  assign out_idx   = IW'(w_head.idx);

  // Sticky drop flag: any fire that found no queue slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|(w_fire & ~w_accept));
    end
  end

  assign overflow = r_overflow;

`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] r_cnt [N_NEURONS];
  logic [15:0] r_cnt_data;
  logic [15:0] w_cnt_mux;

  // Select never matches an index at or beyond N_NEURONS, which reads as 0.
  always_comb begin
    w_cnt_mux = 16'd0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (cnt_sel == IW'(i)) begin
        w_cnt_mux = r_cnt[i];
      end else begin
        w_cnt_mux = w_cnt_mux;
      end
    end
  end

  // Enqueued-spike counters and their registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= 16'd0;
      r_cnt_data <= 16'd0;
    end else if (clear) begin
      for (int i = 0; i < N_NEURONS; i++) r_cnt[i] <= 16'd0;
      r_cnt_data <= 16'd0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (w_accept[i] && (r_cnt[i] != 16'hFFFF)) r_cnt[i] <= r_cnt[i] + 16'd1;
      end
      r_cnt_data <= w_cnt_mux;
    end
  end

  assign cnt_data = r_cnt_data;
`else
  logic w_unused_cnt_sel;
  assign w_unused_cnt_sel = ^cnt_sel;
  assign cnt_data         = 16'd0;
`endif

endmodule
